// File: rtl/vga_pkg.sv
// Shared colour constants, mode encodings and the bar palette used by the VGA test-pattern source.
package vga_pkg;

  localparam int unsigned ADDR_W = 11;
  localparam int unsigned POS_W  = 12;
  localparam int unsigned RGB_W  = 24;

  typedef logic [RGB_W-1:0] rgb_t;

  localparam rgb_t BLACK    = 24'h000000;
  localparam rgb_t RED      = 24'hFF0000;
  localparam rgb_t GREEN    = 24'h00FF00;
  localparam rgb_t BLUE     = 24'h0000FF;
  localparam rgb_t YELLOW   = 24'hFFFF00;
  localparam rgb_t SKY_BLUE = 24'h87CEEB;
  localparam rgb_t PURPLE   = 24'hA020F0;
  localparam rgb_t GRAY     = 24'h808080;
  localparam rgb_t WHITE    = 24'hFFFFFF;

  typedef enum logic [1:0] {
    MODE_VBAR  = 2'd0,
    MODE_HBAR  = 2'd1,
    MODE_CHECK = 2'd2,
    MODE_BOX   = 2'd3
  } mode_e;

  // Top-left corner of the bouncing box in active-area coordinates.
  typedef struct packed {
    logic [ADDR_W-1:0] x;
    logic [ADDR_W-1:0] y;
  } box_pos_t;

  // Eight-entry bar palette, index wraps modulo 8.
  function automatic rgb_t palette(input logic [2:0] idx);
    rgb_t c;
    case (idx)
      3'd0:    c = WHITE;
      3'd1:    c = YELLOW;
      3'd2:    c = SKY_BLUE;
      3'd3:    c = GREEN;
      3'd4:    c = PURPLE;
      3'd5:    c = RED;
      3'd6:    c = BLUE;
      default: c = BLACK;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/vga_box_mover.sv
// Bouncing-box position state: steps once per frame end and reflects off the active-area edges.
module vga_box_mover
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE = 640,
  parameter int unsigned V_ACTIVE = 480,
  parameter int unsigned BOX_SIZE = 64,
  parameter int unsigned BOX_STEP = 2
) (
  input  logic     clk,
  input  logic     rst_n,
  input  logic     fe,
  output box_pos_t box
);

  localparam logic [POS_W-1:0] H_LIM = POS_W'(H_ACTIVE);
  localparam logic [POS_W-1:0] V_LIM = POS_W'(V_ACTIVE);
  localparam logic [POS_W-1:0] SIZE  = POS_W'(BOX_SIZE);
  localparam logic [POS_W-1:0] STEP  = POS_W'(BOX_STEP);

  typedef struct packed {
    logic [POS_W-1:0] pos;
    logic             dir;
  } axis_t;

  logic [ADDR_W-1:0] x_q, y_q;
  logic              dx_q, dy_q;
  axis_t             x_nxt, y_nxt;

  // One axis step; a bounce reverses direction and moves one step back the other way.
  function automatic axis_t step_axis(input logic [POS_W-1:0] pos,
                                      input logic             dir,
                                      input logic [POS_W-1:0] lim);
    axis_t r;
    r.dir = dir;
    r.pos = pos;
    if (dir) begin
      if (pos + SIZE + STEP > lim) begin
        r.dir = 1'b0;
        r.pos = pos - STEP;
      end else begin
        r.pos = pos + STEP;
      end
    end else begin
      if (pos < STEP) begin
        r.dir = 1'b1;
        r.pos = pos + STEP;
      end else begin
        r.pos = pos - STEP;
      end
    end
    return r;
  endfunction

  always_comb begin
    x_nxt = step_axis({1'b0, x_q}, dx_q, H_LIM);
    y_nxt = step_axis({1'b0, y_q}, dy_q, V_LIM);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q  <= '0;
      y_q  <= '0;
      dx_q <= 1'b1;
      dy_q <= 1'b1;
    end else if (fe) begin
      x_q  <= ADDR_W'(x_nxt.pos);
      y_q  <= ADDR_W'(y_nxt.pos);
      dx_q <= x_nxt.dir;
      dy_q <= y_nxt.dir;
    end
  end

  assign box = '{x: x_q, y: y_q};

endmodule

// File: rtl/vga_pattern_gen.sv
// Selectable VGA test-pattern source: bars, checkerboard or bouncing box, mode switched at frame end.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned BAR_NUM     = 8,
  parameter int unsigned CHECK_SHIFT = 5,
  parameter int unsigned BOX_SIZE    = 64,
  parameter int unsigned BOX_STEP    = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [1:0]        mode_i,
  input  logic              de_i,
  input  logic [ADDR_W-1:0] h_addr,
  input  logic [ADDR_W-1:0] v_addr,
  output logic [RGB_W-1:0]  data_dis,
  output logic              frame_tick
);

  localparam int unsigned       BAR_W   = H_ACTIVE / BAR_NUM;
  localparam int unsigned       BAR_H   = V_ACTIVE / BAR_NUM;
  localparam logic [ADDR_W-1:0] H_LAST  = ADDR_W'(H_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] V_LAST  = ADDR_W'(V_ACTIVE - 1);
  localparam logic [ADDR_W-1:0] H_LIM   = ADDR_W'(H_ACTIVE);
  localparam logic [ADDR_W-1:0] V_LIM   = ADDR_W'(V_ACTIVE);
  localparam logic [ADDR_W-1:0] BAR_WD  = ADDR_W'(BAR_W);
  localparam logic [ADDR_W-1:0] BAR_HD  = ADDR_W'(BAR_H);
  localparam logic [POS_W-1:0]  BOX_EXT = POS_W'(BOX_SIZE);

  logic             fe_c;
  logic             in_area_c;
  logic             in_box_c;
  logic [POS_W-1:0] h_ext, v_ext, bx_ext, by_ext;
  mode_e            mode_q;
  box_pos_t         box;
  rgb_t             pix_c;

  assign fe_c      = de_i && (h_addr == H_LAST) && (v_addr == V_LAST);
  assign in_area_c = de_i && (h_addr < H_LIM) && (v_addr < V_LIM);

  // Mode only changes at frame end so a frame is never drawn in two patterns.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= MODE_VBAR;
    end else if (fe_c) begin
      mode_q <= mode_e'(mode_i);
    end
  end

  vga_box_mover #(
    .H_ACTIVE (H_ACTIVE),
    .V_ACTIVE (V_ACTIVE),
    .BOX_SIZE (BOX_SIZE),
    .BOX_STEP (BOX_STEP)
  ) u_box_mover (
    .clk   (clk),
    .rst_n (rst_n),
    .fe    (fe_c),
    .box   (box)
  );

  // Box containment in 12 bits so box_x + BOX_SIZE cannot wrap.
  always_comb begin
    h_ext    = {1'b0, h_addr};
    v_ext    = {1'b0, v_addr};
    bx_ext   = {1'b0, box.x};
    by_ext   = {1'b0, box.y};
    in_box_c = (h_ext >= bx_ext) && (h_ext < bx_ext + BOX_EXT) &&
               (v_ext >= by_ext) && (v_ext < by_ext + BOX_EXT);
  end

  always_comb begin
    pix_c = BLACK;
    if (in_area_c) begin
      case (mode_q)
        MODE_VBAR:  pix_c = palette(3'(h_addr / BAR_WD));
        MODE_HBAR:  pix_c = palette(3'(v_addr / BAR_HD));
        MODE_CHECK: pix_c = (h_addr[CHECK_SHIFT] ^ v_addr[CHECK_SHIFT]) ? WHITE : BLACK;
        MODE_BOX:   pix_c = in_box_c ? WHITE : BLUE;
        default:    pix_c = BLACK;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_dis   <= BLACK;
      frame_tick <= 1'b0;
    end else begin
      data_dis   <= pix_c;
      frame_tick <= fe_c;
    end
  end

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Directed bench for vga_pattern_gen: vector table for the patterns plus box-bounce and reset sequences.
module tb_vga_pattern_gen;

  localparam logic [23:0] C_BLACK  = 24'h000000;
  localparam logic [23:0] C_RED    = 24'hFF0000;
  localparam logic [23:0] C_GREEN  = 24'h00FF00;
  localparam logic [23:0] C_BLUE   = 24'h0000FF;
  localparam logic [23:0] C_YELLOW = 24'hFFFF00;
  localparam logic [23:0] C_SKY    = 24'h87CEEB;
  localparam logic [23:0] C_PURPLE = 24'hA020F0;
  localparam logic [23:0] C_WHITE  = 24'hFFFFFF;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  mode_i, mode_i2;
  logic        de_i, de_i2;
  logic [10:0] h_addr, v_addr, h_addr2, v_addr2;
  logic [23:0] data_dis, data_dis2;
  logic        frame_tick, frame_tick2;

  always #5 clk = ~clk;

  vga_pattern_gen dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_i     (mode_i),
    .de_i       (de_i),
    .h_addr     (h_addr),
    .v_addr     (v_addr),
    .data_dis   (data_dis),
    .frame_tick (frame_tick)
  );

  // Square 640x640 screen with step 3 so both axes bounce on the same frame.
  vga_pattern_gen #(
    .H_ACTIVE    (640),
    .V_ACTIVE    (640),
    .BAR_NUM     (8),
    .CHECK_SHIFT (5),
    .BOX_SIZE    (64),
    .BOX_STEP    (3)
  ) dut2 (
    .clk        (clk),
    .rst_n      (rst_n),
    .mode_i     (mode_i2),
    .de_i       (de_i2),
    .h_addr     (h_addr2),
    .v_addr     (v_addr2),
    .data_dis   (data_dis2),
    .frame_tick (frame_tick2)
  );

  typedef struct {
    logic        de;
    int          h;
    int          v;
    logic [1:0]  mode;
    logic [23:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad   = 0;
  int   b1x, b1y, d1x, d1y, fes1;
  int   b2x, b2y, d2x, d2y, fes2;

  task automatic chk(input string nm, input logic [23:0] act, input logic [23:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %06h want %06h", nm, act, exp);
    end
  endtask

  // Try the step; if it would leave [0, lim-64], go the other way instead.
  function automatic void bounce(input int p, input int d, input int lim, input int stp,
                                 output int np, output int nd);
    int cand;
    cand = d ? p + stp : p - stp;
    if (cand < 0 || cand + 64 > lim) begin
      nd = d ? 0 : 1;
      np = d ? p - stp : p + stp;
    end else begin
      nd = d;
      np = cand;
    end
  endfunction

  function automatic logic [23:0] box_pix(input int bx, input int by, input int h, input int v,
                                          input int ha, input int va);
    if (h >= ha || v >= va) return C_BLACK;
    return (h >= bx && h < bx + 64 && v >= by && v < by + 64) ? C_WHITE : C_BLUE;
  endfunction

  task automatic px1(input logic de, input int h, input int v, input logic [1:0] md,
                     input logic [23:0] exp, input string nm);
    logic fe;
    de_i = de; h_addr = 11'(h); v_addr = 11'(v); mode_i = md;
    fe = de && h == 639 && v == 479;
    @(posedge clk); #1;
    chk(nm, data_dis, exp);
    chk({nm, "_tick"}, 24'(frame_tick), 24'(fe));
    if (fe) begin
      bounce(b1x, d1x, 640, 2, b1x, d1x);
      bounce(b1y, d1y, 480, 2, b1y, d1y);
      fes1++;
    end
  endtask

  task automatic px2(input logic de, input int h, input int v, input logic [1:0] md,
                     input logic [23:0] exp, input string nm);
    logic fe;
    de_i2 = de; h_addr2 = 11'(h); v_addr2 = 11'(v); mode_i2 = md;
    fe = de && h == 639 && v == 639;
    @(posedge clk); #1;
    chk(nm, data_dis2, exp);
    chk({nm, "_tick"}, 24'(frame_tick2), 24'(fe));
    if (fe) begin
      bounce(b2x, d2x, 640, 3, b2x, d2x);
      bounce(b2y, d2y, 640, 3, b2y, d2y);
      fes2++;
    end
  endtask

  task automatic add(input logic de, input int h, input int v, input logic [1:0] md,
                     input logic [23:0] exp);
    vec_t e;
    e.de = de; e.h = h; e.v = v; e.mode = md; e.exp = exp;
    vecs.push_back(e);
  endtask

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0;
    de_i = 1'b0; h_addr = '0; v_addr = '0; mode_i = 2'd0;
    de_i2 = 1'b0; h_addr2 = '0; v_addr2 = '0; mode_i2 = 2'd3;
    b1x = 0; b1y = 0; d1x = 1; d1y = 1; fes1 = 0;
    b2x = 0; b2y = 0; d2x = 1; d2y = 1; fes2 = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_data", data_dis, C_BLACK);
    chk("rst_tick", 24'(frame_tick), 24'h0);
    chk("rst_data2", data_dis2, C_BLACK);
    rst_n = 1'b1;

    // Frame A: vbars; mode_i moves to 2 mid-frame and must not take effect yet.
    add(1, 0, 0, 0, C_WHITE);     add(1, 79, 10, 0, C_WHITE);
    add(1, 80, 10, 0, C_YELLOW);  add(1, 159, 10, 0, C_YELLOW);
    add(1, 160, 10, 0, C_SKY);    add(1, 240, 10, 0, C_GREEN);
    add(1, 320, 10, 2, C_PURPLE); add(1, 400, 10, 2, C_RED);
    add(1, 480, 10, 2, C_BLUE);   add(1, 560, 10, 2, C_BLACK);
    add(1, 100, 479, 2, C_YELLOW);
    add(0, 100, 10, 2, C_BLACK);  add(1, 640, 10, 2, C_BLACK);
    add(1, 10, 480, 2, C_BLACK);  add(0, 639, 479, 2, C_BLACK);
    add(1, 639, 478, 2, C_BLACK); add(1, 639, 479, 2, C_BLACK);
    // Frame B: checker; request hbars for next frame.
    add(1, 32, 0, 1, C_WHITE);    add(1, 0, 0, 1, C_BLACK);
    add(1, 32, 32, 1, C_BLACK);   add(1, 0, 32, 1, C_WHITE);
    add(1, 64, 0, 1, C_BLACK);    add(1, 96, 0, 1, C_WHITE);
    add(0, 32, 0, 1, C_BLACK);    add(1, 639, 479, 1, C_WHITE);
    // Frame C: hbars; request box.
    add(1, 0, 0, 3, C_WHITE);     add(1, 600, 59, 3, C_WHITE);
    add(1, 300, 60, 3, C_YELLOW); add(1, 100, 240, 3, C_PURPLE);
    add(1, 639, 419, 3, C_BLUE);  add(1, 5, 420, 3, C_BLACK);
    add(1, 639, 479, 3, C_BLACK);
    // Frame D: box at (6,6) after three frame ends.
    add(1, 6, 6, 3, C_WHITE);     add(1, 69, 69, 3, C_WHITE);
    add(1, 70, 6, 3, C_BLUE);     add(1, 5, 6, 3, C_BLUE);
    add(1, 6, 70, 3, C_BLUE);     add(1, 6, 5, 3, C_BLUE);
    add(0, 6, 6, 3, C_BLACK);     add(1, 639, 479, 3, C_BLUE);

    foreach (vecs[i])
      px1(vecs[i].de, vecs[i].h, vecs[i].v, vecs[i].mode, vecs[i].exp, $sformatf("vec%0d", i));

    // Box sweep over 300 frames with hand-checked bounce frames.
    while (fes1 < 300) begin
      px1(1, b1x, b1y, 3, C_WHITE, "box_tl");
      px1(1, b1x + 64, b1y, 3, box_pix(b1x, b1y, b1x + 64, b1y, 640, 480), "box_right");
      if (fes1 == 208) begin
        px1(1, 416, 416, 3, C_WHITE, "y416_tl");
        px1(1, 416, 479, 3, C_WHITE, "y416_bot");
      end
      if (fes1 == 209) begin
        px1(1, 418, 477, 3, C_WHITE, "y414_bot");
        px1(1, 418, 478, 3, C_BLUE, "y414_below");
      end
      if (fes1 == 288) begin
        px1(1, 576, 256, 3, C_WHITE, "x576_tl");
        px1(1, 575, 256, 3, C_BLUE, "x576_left");
        px1(1, 639, 256, 3, C_WHITE, "x576_edge");
      end
      if (fes1 == 289) begin
        px1(1, 574, 254, 3, C_WHITE, "x574_tl");
        px1(1, 573, 254, 3, C_BLUE, "x574_left");
        px1(1, 637, 254, 3, C_WHITE, "x574_right");
        px1(1, 638, 254, 3, C_BLUE, "x574_out");
      end
      px1(1, 639, 479, 3, box_pix(b1x, b1y, 639, 479, 640, 480), "fe_box");
    end
    de_i = 1'b0;

    // Second instance: first frame is still vbars, then box with corner bounces.
    px2(1, 639, 639, 3, C_BLACK, "d2_prime");
    while (fes2 < 400) begin
      px2(1, b2x, b2y, 3, C_WHITE, "d2_tl");
      px2(1, b2x + 63, b2y, 3, C_WHITE, "d2_tr");
      px2(1, b2x, b2y + 63, 3, C_WHITE, "d2_bl");
      px2(1, b2x + 64, b2y, 3, box_pix(b2x, b2y, b2x + 64, b2y, 640, 640), "d2_right");
      if (b2x > 0)
        px2(1, b2x - 1, b2y, 3, C_BLUE, "d2_left");
      if (fes2 == 192) begin
        px2(1, 576, 576, 3, C_WHITE, "c576_tl");
        px2(1, 575, 575, 3, C_BLUE, "c576_out");
      end
      if (fes2 == 193) begin
        px2(1, 573, 573, 3, C_WHITE, "c573_tl");
        px2(1, 636, 636, 3, C_WHITE, "c573_br");
        px2(1, 637, 637, 3, C_BLUE, "c573_out");
      end
      if (fes2 == 384) begin
        px2(1, 0, 0, 3, C_WHITE, "c0_tl");
        px2(1, 64, 0, 3, C_BLUE, "c0_right");
      end
      if (fes2 == 385) begin
        px2(1, 3, 3, 3, C_WHITE, "c3_tl");
        px2(1, 2, 3, 3, C_BLUE, "c3_left");
        px2(1, 66, 66, 3, C_WHITE, "c3_br");
        px2(1, 67, 3, 3, C_BLUE, "c3_right");
      end
      px2(1, 639, 639, 3, box_pix(b2x, b2y, 639, 639, 640, 640), "d2_fe");
    end
    de_i2 = 1'b0;

    // Mid-frame async reset while showing the box.
    px1(1, b1x, b1y, 3, C_WHITE, "pre_rst");
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_data", data_dis, C_BLACK);
    chk("rst_mid_tick", 24'(frame_tick), 24'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    b1x = 0; b1y = 0; d1x = 1; d1y = 1;
    px1(1, 0, 100, 3, C_WHITE, "post_rst_vbar");
    px1(1, 639, 479, 3, C_BLACK, "post_rst_fe");
    px1(1, 2, 2, 3, C_WHITE, "post_rst_box");
    px1(1, 1, 2, 3, C_BLUE, "post_rst_left");
    px1(1, 65, 65, 3, C_WHITE, "post_rst_br");
    px1(1, 66, 2, 3, C_BLUE, "post_rst_right");
    px1(1, 2, 66, 3, C_BLUE, "post_rst_below");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
